gshare_pht: RTL and testbench
=============================

# gshare_pht

Pattern history table with gshare indexing for the fetch-stage branch predictor. Holds 2^INDEX_W two-bit saturating counters and a speculative global history register (GHR). Produces a registered taken/not-taken prediction per lookup and retires resolved outcomes from the execute stage. On a mispredict it repairs the GHR from the snapshot carried with the branch.

## Interface
- GHR_W, 8: global history length; must satisfy 2 ≤ GHR_W ≤ INDEX_W
- INDEX_W, 8: PHT index width; the table has 2^INDEX_W entries
- PC_W, 32: program counter width
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- pred_valid  in  1  lookup request this cycle
- pred_pc  in  PC_W  PC of the branch being looked up
- pred_out_valid  out  1  prediction valid; follows the accepted lookup by one cycle
- pred_taken  out  1  predicted direction
- pred_ghr  out  GHR_W  GHR value used for the lookup; travels down the pipe with the branch
- upd_valid  in  1  resolved-branch update
- upd_pc  in  PC_W  PC of the resolved branch
- upd_ghr  in  GHR_W  snapshot returned from pred_ghr
- upd_taken  in  1  actual outcome
- upd_mispredict  in  1  resolved direction differed from the prediction

## Operation
- Index: idx(pc, g) = pc[INDEX_W+1:2] XOR zero_extend(g, INDEX_W).
- Counter encoding: 11 = strongly taken, 10 = weakly taken, 01 = weakly not-taken, 00 = strongly not-taken. The prediction is counter bit 1.
- Counter update when upd_valid is high: the entry at idx(upd_pc, upd_ghr) increments on taken and saturates at 11. It decrements on not-taken and saturates at 00. The update is written on the clock edge.
- Lookup: the table is read combinationally at idx(pred_pc, ghr). On the edge, pred_taken, pred_ghr (the pre-shift GHR) and pred_out_valid=1 are registered, and the GHR shifts as {ghr[GHR_W-2:0], predicted bit}.
- Same-cycle bypass: if a lookup and a non-mispredict update target the same index, the prediction uses the post-update counter value.
- Mispredict repair: if upd_valid and upd_mispredict are both high, the GHR becomes {upd_ghr[GHR_W-2:0], upd_taken}. Any pred_valid in that same cycle is dropped: no GHR shift, and pred_out_valid=0 on the next cycle. The counter update still occurs.
- An update with upd_mispredict=0 does not touch the GHR.
- If pred_valid=0, pred_out_valid=0 next cycle. pred_taken and pred_ghr hold their last values.

## Timing
- Reset (asynchronous assertion, takes effect with no clock edge):
  - all counters = 11
  - GHR = 0
  - pred_out_valid = 0, pred_taken = 0, pred_ghr = 0
- Deassertion takes effect at the next rising edge.
- Lookup latency is one cycle; one lookup and one update can be accepted every cycle, with no stalls.
- Update-to-lookup visibility: 0 cycles for the same index (bypass). For different indices it is the next edge.
- Reset mid-operation: all in-flight predictions are lost and pred_out_valid drops immediately.
- Mispredict repair takes effect for a lookup issued on the next cycle.

## Structure
- Shared package bp_pkg:
  - counter state constants ST_STRONG_T = 2'b11, ST_WEAK_T = 2'b10, ST_WEAK_NT = 2'b01, ST_STRONG_NT = 2'b00
  - a two-bit counter typedef
- Sub-module pht_counter_next: combinational saturating next-state function (state, taken → next state), used by both the write path and the bypass path.
- The table is a flop array, so that asynchronous reset of every entry is possible. There is no SRAM macro.

## Test plan
(Default parameters throughout.)
1. Reset, then a lookup with pred_pc=0x00000010 → one cycle later: pred_out_valid=1, pred_taken=1, pred_ghr=0x00; the internal GHR becomes 0x01.
2. After reset, three updates with upd_pc=0x10, upd_ghr=0x00, upd_taken=0, upd_mispredict=0 (counter 11→10→01→00), then a lookup at pred_pc=0x10 → pred_taken=0.
3. Counter sitting at 00 after a fourth not-taken update: one taken update gives 01 and a lookup predicts 0; a second taken update gives 10 and a lookup predicts 1.
4. upd_valid=1, upd_mispredict=1, upd_ghr=0x5A, upd_taken=1, with pred_valid=1 in the same cycle → next cycle pred_out_valid=0; a following lookup reports pred_ghr=0xB5.
5. Counter at index 0x04 equal to 10, then a same-cycle lookup at pred_pc=0x10 (GHR 0) and update (upd_pc=0x10, upd_ghr=0x00, upd_taken=0) → pred_taken=0 and the stored counter is 01.
6. Drop resetn between clock edges during back-to-back lookups → pred_out_valid goes to 0 immediately; after release, the first lookup again predicts taken with pred_ghr=0x00.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared branch-predictor types: two-bit saturating counter encoding.
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t ST_STRONG_T  = 2'b11;
    localparam ctr_t ST_WEAK_T    = 2'b10;
    localparam ctr_t ST_WEAK_NT   = 2'b01;
    localparam ctr_t ST_STRONG_NT = 2'b00;

    function automatic logic ctr_taken(ctr_t c);
        return c[1];
    endfunction

endpackage

// File: rtl/gshare_pht_if.sv
// Lookup and resolved-update channels between fetch/execute and the gshare PHT.
interface gshare_pht_if #(
    parameter int unsigned GHR_W = 8,
    parameter int unsigned PC_W  = 32
);
    logic             pred_valid;
    logic [PC_W-1:0]  pred_pc;
    logic             pred_out_valid;
    logic             pred_taken;
    logic [GHR_W-1:0] pred_ghr;

    logic             upd_valid;
    logic [PC_W-1:0]  upd_pc;
    logic [GHR_W-1:0] upd_ghr;
    logic             upd_taken;
    logic             upd_mispredict;

    modport master (
        output pred_valid, pred_pc,
        output upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict,
        input  pred_out_valid, pred_taken, pred_ghr
    );

    modport slave (
        input  pred_valid, pred_pc,
        input  upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict,
        output pred_out_valid, pred_taken, pred_ghr
    );
endinterface

// File: rtl/pht_counter_next.sv
// Saturating next-state function for a two-bit direction counter.
module pht_counter_next
    import bp_pkg::*;
(
    input  ctr_t state_i,
    input  logic taken_i,
    output ctr_t next_o
);

    always_comb begin
        next_o = state_i;
        if (taken_i) begin
            if (state_i != ST_STRONG_T) next_o = state_i + 2'd1;
        end else begin
            if (state_i != ST_STRONG_NT) next_o = state_i - 2'd1;
        end
    end

endmodule

// File: rtl/gshare_pht.sv
// Gshare pattern history table: flop-array counters, speculative GHR and
// mispredict repair from the snapshot returned with the resolved branch.
module gshare_pht
    import bp_pkg::*;
#(
    parameter int unsigned GHR_W   = 8,
    parameter int unsigned INDEX_W = 8,
    parameter int unsigned PC_W    = 32
) (
    input  logic         clk,
    input  logic         resetn,
    gshare_pht_if.slave  bus
);

    localparam int unsigned Entries = 1 << INDEX_W;

    ctr_t               pht_q [Entries];
    logic [GHR_W-1:0]   ghr_q, ghr_d;
    logic               pred_valid_q, pred_valid_d;
    logic               pred_taken_q, pred_taken_d;
    logic [GHR_W-1:0]   pred_ghr_q, pred_ghr_d;

    logic [INDEX_W-1:0] pred_idx, upd_idx;
    ctr_t               upd_next, pred_ctr;
    logic               repair, lookup;

    assign pred_idx = bus.pred_pc[INDEX_W+1:2] ^ INDEX_W'(ghr_q);
    assign upd_idx  = bus.upd_pc[INDEX_W+1:2] ^ INDEX_W'(bus.upd_ghr);

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.pred_pc[PC_W-1:INDEX_W+2], bus.pred_pc[1:0],
                              bus.upd_pc[PC_W-1:INDEX_W+2], bus.upd_pc[1:0]};

    // One next-state instance feeds both the table write and the bypass.
    pht_counter_next u_ctr_next (
        .state_i (pht_q[upd_idx]),
        .taken_i (bus.upd_taken),
        .next_o  (upd_next)
    );

    assign repair = bus.upd_valid && bus.upd_mispredict;
    assign lookup = bus.pred_valid && !repair;

    always_comb begin
        pred_ctr = pht_q[pred_idx];
        if (bus.upd_valid && !bus.upd_mispredict && (upd_idx == pred_idx)) begin
            pred_ctr = upd_next;
        end
    end

    always_comb begin
        ghr_d        = ghr_q;
        pred_valid_d = lookup;
        pred_taken_d = pred_taken_q;
        pred_ghr_d   = pred_ghr_q;
        if (repair) begin
            ghr_d = {bus.upd_ghr[GHR_W-2:0], bus.upd_taken};
        end else if (lookup) begin
            ghr_d        = {ghr_q[GHR_W-2:0], ctr_taken(pred_ctr)};
            pred_taken_d = ctr_taken(pred_ctr);
            pred_ghr_d   = ghr_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < Entries; i++) begin
                pht_q[i] <= ST_STRONG_T;
            end
        end else if (bus.upd_valid) begin
            pht_q[upd_idx] <= upd_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ghr_q        <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_ghr_q   <= '0;
        end else begin
            ghr_q        <= ghr_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_ghr_q   <= pred_ghr_d;
        end
    end

    assign bus.pred_out_valid = pred_valid_q;
    assign bus.pred_taken     = pred_taken_q;
    assign bus.pred_ghr       = pred_ghr_q;

endmodule

// File: tb/tb_gshare_pht.sv
// Bench for gshare_pht: integer reference model checked every cycle, plus
// literal expectations from hand-worked scenarios.
module tb_gshare_pht;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    gshare_pht_if #(.GHR_W(8), .PC_W(32)) bus ();

    gshare_pht #(.GHR_W(8), .INDEX_W(8), .PC_W(32)) dut (
        .clk    (clk),
        .resetn (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counters as integers 0..3, history as an integer mod 256.
    int tbl [256];
    int m_ghr;
    int m_valid, m_taken, m_pghr;

    function automatic int idx_of(input logic [31:0] pc, input int g);
        return ((int'(pc) >> 2) ^ g) & 255;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) tbl[i] <= 3;
            m_ghr   <= 0;
            m_valid <= 0;
            m_taken <= 0;
            m_pghr  <= 0;
        end else begin
            automatic int ui = idx_of(bus.upd_pc, int'(bus.upd_ghr));
            automatic int nv = bus.upd_taken ? ((tbl[ui] < 3) ? tbl[ui] + 1 : 3)
                                             : ((tbl[ui] > 0) ? tbl[ui] - 1 : 0);
            automatic int pi = idx_of(bus.pred_pc, m_ghr);
            automatic int pc = (bus.upd_valid && pi == ui) ? nv : tbl[pi];
            if (bus.upd_valid) tbl[ui] <= nv;
            if (bus.upd_valid && bus.upd_mispredict) begin
                m_ghr   <= ((int'(bus.upd_ghr) << 1) | int'(bus.upd_taken)) & 255;
                m_valid <= 0;
            end else if (bus.pred_valid) begin
                m_valid <= 1;
                m_taken <= (pc >= 2) ? 1 : 0;
                m_pghr  <= m_ghr;
                m_ghr   <= ((m_ghr << 1) | ((pc >= 2) ? 1 : 0)) & 255;
            end else begin
                m_valid <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("model_valid", 32'(bus.pred_out_valid), 32'(m_valid));
            check("model_taken", 32'(bus.pred_taken), 32'(m_taken));
            check("model_ghr", 32'(bus.pred_ghr), 32'(m_pghr));
        end
    end

    task automatic drive(input logic pv, input logic [31:0] ppc, input logic uv,
                         input logic [31:0] upc, input logic [7:0] ughr,
                         input logic ut, input logic um);
        @(negedge clk);
        bus.pred_valid     = pv;
        bus.pred_pc        = ppc;
        bus.upd_valid      = uv;
        bus.upd_pc         = upc;
        bus.upd_ghr        = ughr;
        bus.upd_taken      = ut;
        bus.upd_mispredict = um;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic lookup(input logic [31:0] pc);
        drive(1'b1, pc, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic update(input logic [31:0] pc, input logic [7:0] g, input logic t);
        drive(1'b0, 32'h0, 1'b1, pc, g, t, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n              = 1'b0;
        bus.pred_valid     = 1'b0;
        bus.upd_valid      = 1'b0;
        bus.upd_mispredict = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.pred_valid     = 1'b0;
        bus.pred_pc        = '0;
        bus.upd_valid      = 1'b0;
        bus.upd_pc         = '0;
        bus.upd_ghr        = '0;
        bus.upd_taken      = 1'b0;
        bus.upd_mispredict = 1'b0;
        #1;
        check("rst_valid", 32'(bus.pred_out_valid), 32'd0);
        check("rst_taken", 32'(bus.pred_taken), 32'd0);
        check("rst_ghr", 32'(bus.pred_ghr), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // First lookup after reset: counters strongly taken, GHR 0 -> 1.
        lookup(32'h10);
        idle();
        check("t1_valid", 32'(bus.pred_out_valid), 32'd1);
        check("t1_taken", 32'(bus.pred_taken), 32'd1);
        check("t1_ghr", 32'(bus.pred_ghr), 32'h00);
        lookup(32'h10);
        idle();
        check("t1_ghr_shift", 32'(bus.pred_ghr), 32'h01);
        idle();
        check("t1_idle_valid", 32'(bus.pred_out_valid), 32'd0);
        check("t1_idle_hold", 32'(bus.pred_ghr), 32'h01);

        // Three not-taken updates walk index 0x04 down to 00.
        do_reset();
        repeat (3) update(32'h10, 8'h00, 1'b0);
        lookup(32'h10);
        idle();
        check("t2_taken", 32'(bus.pred_taken), 32'd0);

        // Saturate at 00, then climb back to 01 and 10.
        update(32'h10, 8'h00, 1'b0);
        update(32'h10, 8'h00, 1'b1);
        lookup(32'h10);
        idle();
        check("t3_taken_01", 32'(bus.pred_taken), 32'd0);
        update(32'h10, 8'h00, 1'b1);
        lookup(32'h10);
        idle();
        check("t3_taken_10", 32'(bus.pred_taken), 32'd1);

        // Repair GHR to 0, then same-cycle lookup and update on index 0x04 (10 -> 01).
        drive(1'b0, 32'h0, 1'b1, 32'h100, 8'h00, 1'b0, 1'b1);
        drive(1'b1, 32'h10, 1'b1, 32'h10, 8'h00, 1'b0, 1'b0);
        idle();
        check("t5_bypass_taken", 32'(bus.pred_taken), 32'd0);
        check("t5_bypass_ghr", 32'(bus.pred_ghr), 32'h00);
        lookup(32'h10);
        idle();
        check("t5_stored_not_t", 32'(bus.pred_taken), 32'd0);
        update(32'h10, 8'h00, 1'b1);
        lookup(32'h10);
        idle();
        check("t5_stored_is_01", 32'(bus.pred_taken), 32'd1);

        // Mispredict drops the concurrent lookup and repairs the GHR.
        drive(1'b1, 32'h10, 1'b1, 32'h20, 8'h5A, 1'b1, 1'b1);
        lookup(32'h40);
        check("t4_dropped", 32'(bus.pred_out_valid), 32'd0);
        idle();
        check("t4_valid", 32'(bus.pred_out_valid), 32'd1);
        check("t4_ghr", 32'(bus.pred_ghr), 32'hB5);

        // Mixed traffic, checked against the model every cycle.
        for (int i = 0; i < 48; i++) begin
            drive((i % 3) != 0, 32'((i * 36) & 32'hFFC), (i % 2) == 1,
                  32'(((i * 5) % 8) << 2), 8'((i * 7) & 255), (i % 3) == 1, (i % 7) == 3);
        end
        idle();

        // Asynchronous reset in the middle of back-to-back lookups.
        lookup(32'h10);
        lookup(32'h14);
        @(posedge clk);
        #2;
        check("t6_pre_valid", 32'(bus.pred_out_valid), 32'd1);
        rst_n          = 1'b0;
        bus.pred_valid = 1'b0;
        #1;
        check("t6_async_valid", 32'(bus.pred_out_valid), 32'd0);
        check("t6_async_ghr", 32'(bus.pred_ghr), 32'h00);
        @(negedge clk);
        #1 rst_n = 1'b1;
        lookup(32'h10);
        idle();
        check("t6_valid", 32'(bus.pred_out_valid), 32'd1);
        check("t6_taken", 32'(bus.pred_taken), 32'd1);
        check("t6_ghr", 32'(bus.pred_ghr), 32'h00);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
